// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code datapath: sequencer state encoding and
// a width-agnostic binary-to-Gray helper.
package gray_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } gray_seq_state_t;

    // Callers zero-extend into this width and truncate the result back. The top
    // bit of a narrower code is still correct, because the extension bit is 0.
    localparam int unsigned GRAY_MAX_W = 64;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_seq_gen.sv
// Programmable Gray-code run generator on a valid/ready stream: steps a binary
// counter up or down from a start value and emits each count as a Gray code.
module gray_seq_gen
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] start_val,
    input  logic [WIDTH-1:0] len,
    input  logic             dir,
    input  logic             abort,
    output logic [WIDTH-1:0] gray_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             last_o,
    output logic             busy_o,
    output logic             done_o
);

    gray_seq_state_t state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             xfer;

    assign xfer = valid_q && ready_i;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned; that is what keeps this block from inferring latches.
        state_d = state_q;
        bin_d   = bin_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        gray_d  = gray_q;
        valid_d = valid_q;
        last_d  = last_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    bin_d   = start_val;
                    rem_d   = len;
                    dir_d   = dir;
                    gray_d  = WIDTH'(bin2gray(GRAY_MAX_W'(start_val)));
                    valid_d = 1'b1;
                    last_d  = (len == '0);
                end
            end

            RUN: begin
                // Abort takes priority; a coincident transfer is still consumed
                // downstream, but the run ends without a done pulse.
                if (abort) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end else if (xfer) begin
                    if (rem_q == '0) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        bin_d  = dir_q ? (bin_q - WIDTH'(1)) : (bin_q + WIDTH'(1));
                        rem_d  = rem_q - WIDTH'(1);
                        gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));
                        last_d = (rem_d == '0);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            gray_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge value of its neighbours, independent of statement order.
            state_q <= state_d;
            bin_q   <= bin_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            gray_q  <= gray_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign gray_o  = gray_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == DONE);

endmodule

// File: tb/tb_gray_seq_gen.sv
// Directed bench for gray_seq_gen: hand-computed Gray sequences, wrap, stall,
// abort, mid-run start and asynchronous reset.
module tb_gray_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] start_val;
    logic [7:0] len;
    logic       dir;
    logic       abort;
    logic [7:0] gray_o;
    logic       valid_o;
    logic       ready_i;
    logic       last_o;
    logic       busy_o;
    logic       done_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_g [$];

    gray_seq_gen #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .start_val (start_val),
        .len       (len),
        .dir       (dir),
        .abort     (abort),
        .gray_o    (gray_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .last_o    (last_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference Gray-to-binary converter applied to gray_o.
    function automatic logic [7:0] gray2bin(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Called at a sample point (1 time unit after a rising edge). Plays a run
    // with ready_i high, comparing against exp_g. abort_at / poke_at are code
    // indices at which abort or a spurious start is driven (-1 = never).
    task automatic do_run(input logic [7:0] sv, input logic [7:0] ln, input logic d,
                          input int abort_at, input int poke_at);
        int n_codes;
        logic [7:0] exp_bin;
        n_codes   = (abort_at >= 0) ? abort_at + 1 : exp_g.size();
        ready_i   = 1'b1;
        start     = 1'b1;
        start_val = sv;
        len       = ln;
        dir       = d;
        @(posedge clk); #1;
        start     = 1'b0;
        start_val = 8'h55;
        len       = 8'h00;
        dir       = ~d;
        for (int i = 0; i < n_codes; i++) begin
            exp_bin = d ? (sv - 8'(i)) : (sv + 8'(i));
            check("valid", 32'(valid_o), 32'd1);
            check("gray", 32'(gray_o), 32'(exp_g[i]));
            check("conv_bin", 32'(gray2bin(gray_o)), 32'(exp_bin));
            check("last", 32'(last_o), 32'(i == int'(ln)));
            check("done_in_run", 32'(done_o), 32'd0);
            if (i == abort_at) abort = 1'b1;
            if (i == poke_at) begin
                start     = 1'b1;
                start_val = 8'hAA;
                len       = 8'h00;
            end
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
        end
        check("valid_end", 32'(valid_o), 32'd0);
        if (abort_at >= 0) begin
            check("abort_no_done", 32'(done_o), 32'd0);
            check("abort_idle", 32'(busy_o), 32'd0);
            @(posedge clk); #1;
            check("abort_no_done_late", 32'(done_o), 32'd0);
        end else begin
            check("done_pulse", 32'(done_o), 32'd1);
            check("busy_in_done", 32'(busy_o), 32'd1);
            @(posedge clk); #1;
            check("done_cleared", 32'(done_o), 32'd0);
            check("busy_dropped", 32'(busy_o), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] held_g;
        logic       held_l;
        logic       was_valid;
        logic       rdy;
        int         count;
        logic       seen_done;

        rst_n     = 1'b0;
        start     = 1'b0;
        start_val = 8'h00;
        len       = 8'h00;
        dir       = 1'b0;
        abort     = 1'b0;
        ready_i   = 1'b1;
        #3;
        check("rst_gray", 32'(gray_o), 32'd0);
        check("rst_flags", {27'd0, valid_o, last_o, busy_o, done_o, 1'b0}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic up-count from zero.
        exp_g = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};
        do_run(8'h00, 8'd7, 1'b0, -1, -1);

        // Wrap upwards through 0xFF.
        exp_g = '{8'h81, 8'h80, 8'h00, 8'h01};
        do_run(8'hFE, 8'd3, 1'b0, -1, -1);

        // Wrap downwards through 0x00.
        exp_g = '{8'h01, 8'h00, 8'h80};
        do_run(8'h01, 8'd2, 1'b1, -1, -1);

        // Single-code run.
        exp_g = '{8'h07};
        do_run(8'h05, 8'd0, 1'b0, -1, -1);

        // Start pulsed mid-run must not disturb the sequence.
        exp_g = '{8'h30, 8'h31, 8'h33, 8'h32};
        do_run(8'h20, 8'd3, 1'b0, -1, 1);

        // Abort while the third code is presented.
        exp_g = '{8'h60, 8'h61, 8'h63, 8'h62, 8'h66, 8'h67};
        do_run(8'h40, 8'd5, 1'b0, 2, -1);

        // Backpressure with random ready_i.
        exp_g     = '{8'h18, 8'h19, 8'h1B, 8'h1A, 8'h1E};
        start     = 1'b1;
        start_val = 8'h10;
        len       = 8'd4;
        dir       = 1'b0;
        @(posedge clk); #1;
        start     = 1'b0;
        start_val = 8'hC3;
        count     = 0;
        seen_done = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (done_o) begin
                seen_done = 1'b1;
                break;
            end
            rdy       = 1'($urandom_range(0, 1));
            ready_i   = rdy;
            held_g    = gray_o;
            held_l    = last_o;
            was_valid = valid_o;
            if (was_valid && rdy) begin
                if (count < 5) begin
                    check("bp_gray", 32'(gray_o), 32'(exp_g[count]));
                    check("bp_last", 32'(last_o), 32'(count == 4));
                end else begin
                    check("bp_extra_xfer", 32'(count + 1), 32'd5);
                end
                count++;
            end
            @(posedge clk); #1;
            if (was_valid && !rdy) begin
                check("bp_hold_valid", 32'(valid_o), 32'd1);
                check("bp_hold_gray", 32'(gray_o), 32'(held_g));
                check("bp_hold_last", 32'(last_o), 32'(held_l));
            end
        end
        check("bp_done_seen", 32'(seen_done), 32'd1);
        check("bp_xfer_count", 32'(count), 32'd5);
        ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_idle", 32'(busy_o), 32'd0);

        // Asynchronous reset in the middle of a run.
        start     = 1'b1;
        start_val = 8'h00;
        len       = 8'd7;
        dir       = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("pre_rst_valid", 32'(valid_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_gray", 32'(gray_o), 32'd0);
        check("async_rst_flags", {27'd0, valid_o, last_o, busy_o, done_o, 1'b0}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", 32'(busy_o), 32'd0);
        exp_g = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04};
        do_run(8'h00, 8'd7, 1'b0, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/gray_seq_gen.md
# gray_seq_gen

Sequential Gray-code source that emits a programmable run of consecutive WIDTH-bit Gray codes on a valid/ready stream. It sits directly upstream of the gray-to-binary converter in the Gray datapath and is the stimulus/pointer generator feeding it. A run starts from a binary start value, steps up or down one count per accepted transfer, wraps modulo 2^WIDTH, and signals completion.

## Interface

- WIDTH, 8, code width in bits (≥2)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; launches a run when idle
- start_val  in  WIDTH  binary value of the first code
- len  in  WIDTH  number of codes in the run minus 1 (1..2^WIDTH codes)
- dir  in  1  0 = count up, 1 = count down
- abort  in  1  terminates an active run
- gray_o  out  WIDTH  current Gray code, equal to bin ^ (bin >> 1)
- valid_o  out  1  gray_o holds a code
- ready_i  in  1  downstream accepts the code
- last_o  out  1  gray_o is the final code of the run (qualified by valid_o)
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse after the last code transfers

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE: on start=1, capture bin ← start_val, rem ← len, dir_q ← dir, then go to RUN. gray_o, valid_o, and last_o are registered from the captured values.
- RUN: valid_o=1 and last_o=(rem==0). A transfer occurs when valid_o && ready_i.
  - On transfer with rem==0: go to DONE, valid_o←0.
  - On transfer with rem!=0: bin ← bin ± 1 (mod 2^WIDTH), rem ← rem − 1.
- Stall: while valid_o && !ready_i, gray_o and last_o are held stable.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- start is ignored in RUN and DONE. start_val, len, and dir are sampled only at the accepted start.
- abort in RUN: go to IDLE next cycle, with valid_o←0 and no done_o.
  - If abort coincides with a transfer, that transfer counts, but abort wins and no done_o is produced.
  - abort in IDLE or DONE has no effect.
- Arithmetic: bin and rem are WIDTH bits with natural wrap.
  - 0xFF+1 → 0x00 and 0x00−1 → 0xFF (for WIDTH=8).
  - len=2^WIDTH−1 covers every code exactly once.
- Reset (asynchronous, any time including mid-run):
  - state=IDLE.
  - gray_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0.
  - Internal bin and rem are cleared to 0.

## Timing

- start accepted at edge N → valid_o=1 with the first code after edge N (1-cycle latency).
- Throughput is one code per cycle while ready_i is held high.
- A run of L=len+1 codes with ready_i constantly high:
  - valid_o is high for L cycles.
  - done_o is high in the cycle after the last transfer.
  - busy_o drops one cycle after that.
- Minimum start-to-start interval is L+2 cycles.
- All outputs are registered; there is no combinational path from ready_i to gray_o.

## Structure

- Shared package gray_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} gray_seq_state_t
  - function bin2gray(bin), parameterised on WIDTH via a localparam or parameterised class
- No sub-module in RTL.
- The bench instantiates the existing gray-to-binary converter on gray_o to check the binary sequence.

## Test plan

- start_val=0x00, len=7, dir=0, ready_i=1 → gray_o = 00,01,03,02,06,07,05,04 on consecutive cycles; last_o only with 04; done_o one cycle later.
- Wrap-up: start_val=0xFE, len=3, dir=0 → gray_o = 81,80,00,01.
- Wrap-down: start_val=0x01, len=2, dir=1 → gray_o = 01,00,80; converter output = 01,00,FF.
- Backpressure: start_val=0x10, len=4, ready_i random at 50% → gray_o stable during stalls; exactly 5 transfers (18,19,1B,1A,1E), no skips or duplicates.
- Control:
  - len=0 → single code with last_o=1, then done_o.
  - start pulsed mid-run → ignored.
  - abort at 3rd code → valid_o low next cycle, no done_o.
- Reset: assert rst_n=0 mid-run asynchronously → all outputs 0 immediately. After release, a new start behaves as in the first scenario.
